// File: rtl/dp_ctrl_if.sv
// Handshake and status bundle between a cipher sequencer and the dp_ctrl controller.
// The master side issues operation requests and byte pairs; the slave side (dp_ctrl)
// returns the datapath step code, handshake ready and status.
interface dp_ctrl_if;
   logic       start;
   logic       mode;
   logic       abort;
   logic       in_valid;
   logic       in_ready;
   logic       out1;
   logic       out2;
   logic       out3;
   logic       dp_clr;
   logic       busy;
   logic       done;
   logic [7:0] op_count;

   modport master (
      output start, mode, abort, in_valid,
      input  in_ready, out1, out2, out3, dp_clr, busy, done, op_count
   );

   modport slave (
      input  start, mode, abort, in_valid,
      output in_ready, out1, out2, out3, dp_clr, busy, done, op_count
   );
endinterface

// File: rtl/dp_ctrl.sv
// Cipher datapath controller. One operation clears the datapath, loads a high and a
// low byte pair (each waiting on in_valid), runs two key steps, holds the encrypt or
// decrypt code for RUN_CYC cycles, then pulses done and bumps the completion counter.
// An abort routes through a single clear cycle back to IDLE without completing.
module dp_ctrl #(
   parameter int unsigned RUN_CYC = 2
) (
   input logic      clka,
   input logic      restart,
   dp_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      LD_HI,
      LD_LO,
      KEY1,
      KEY2,
      RUN,
      DONE
   } state_t;

   // The counter is loaded with RUN_CYC-1 and RUN exits when it reads zero,
   // which gives exactly RUN_CYC cycles in RUN.
   localparam logic [3:0] RUN_LOAD = 4'(RUN_CYC - 1);

   state_t     state;
   state_t     state_nxt;
   logic       mode_q;
   logic       mode_nxt;
   logic       clr_to_idle;
   logic       clr_to_idle_nxt;
   logic [3:0] run_cnt;
   logic [3:0] run_cnt_nxt;
   logic [7:0] op_count_q;
   logic [7:0] op_count_nxt;
   logic [2:0] code;

   // State register and operation context; restart clears everything immediately.
   always_ff @(posedge clka or negedge restart) begin
      if (!restart) begin
         state       <= IDLE;
         mode_q      <= 1'b0;
         clr_to_idle <= 1'b0;
         run_cnt     <= 4'd0;
         op_count_q  <= 8'd0;
      end else begin
         state       <= state_nxt;
         mode_q      <= mode_nxt;
         clr_to_idle <= clr_to_idle_nxt;
         run_cnt     <= run_cnt_nxt;
         op_count_q  <= op_count_nxt;
      end
   end

   // Next-state logic; the CLR cycle remembers whether it came from an abort so it
   // knows to return to IDLE instead of starting the load phase.
   always_comb begin
      state_nxt       = state;
      mode_nxt        = mode_q;
      clr_to_idle_nxt = clr_to_idle;
      run_cnt_nxt     = run_cnt;
      op_count_nxt    = op_count_q;

      case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_nxt       = CLR;
               mode_nxt        = bus.mode;
               clr_to_idle_nxt = 1'b0;
            end
         end
         CLR: begin
            state_nxt = clr_to_idle ? IDLE : LD_HI;
         end
         LD_HI: begin
            if (bus.in_valid) begin
               state_nxt = LD_LO;
            end
         end
         LD_LO: begin
            if (bus.in_valid) begin
               state_nxt = KEY1;
            end
         end
         KEY1: begin
            state_nxt = KEY2;
         end
         KEY2: begin
            state_nxt   = RUN;
            run_cnt_nxt = RUN_LOAD;
         end
         RUN: begin
            if (run_cnt == 4'd0) begin
               state_nxt = DONE;
            end else begin
               run_cnt_nxt = run_cnt - 4'd1;
            end
         end
         DONE: begin
            state_nxt    = IDLE;
            op_count_nxt = op_count_q + 8'd1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Abort wins over in_valid and RUN expiry; IDLE and CLR are not abortable.
      if (bus.abort && (state != IDLE) && (state != CLR)) begin
         state_nxt       = CLR;
         clr_to_idle_nxt = 1'b1;
      end
   end

   // Step code decode from state, latched mode and in_valid only.
   always_comb begin
      code = 3'b000;
      case (state)
         LD_HI:   code = bus.in_valid ? 3'b100 : 3'b000;
         LD_LO:   code = bus.in_valid ? 3'b010 : 3'b000;
         KEY1:    code = 3'b110;
         KEY2:    code = 3'b011;
         RUN:     code = mode_q ? 3'b101 : 3'b001;
         default: code = 3'b000;
      endcase
   end

   assign bus.out1     = code[2];
   assign bus.out2     = code[1];
   assign bus.out3     = code[0];
   assign bus.in_ready = (state == LD_HI) || (state == LD_LO);
   assign bus.dp_clr   = (state == CLR) || !restart;
   assign bus.busy     = (state != IDLE);
   assign bus.done     = (state == DONE);
   assign bus.op_count = op_count_q;

endmodule

// File: tb/tb_dp_ctrl.sv
// Self-checking bench for dp_ctrl: a table of directed vectors, hand-written corner
// sequences and a randomized run, all compared against a sequence-position model.
module tb_dp_ctrl;

   localparam int RUN_CYC  = 2;
   localparam int POS_DONE = 6 + RUN_CYC;

   logic clka = 1'b0;
   logic restart;

   dp_ctrl_if bus ();

   dp_ctrl #(.RUN_CYC(RUN_CYC)) dut (
      .clka    (clka),
      .restart (restart),
      .bus     (bus)
   );

   // Free-running clock, period 10.
   always #5 clka = ~clka;

   typedef struct {
      bit         start;
      bit         mode;
      bit         abort;
      bit         in_valid;
      logic [2:0] code;
      bit         rdy;
      bit         clr;
      bit         bsy;
      bit         dn;
      int         cnt;
   } vec_t;

   vec_t vecs[$];

   int compared   = 0;
   int mismatched = 0;
   bit last_done;

   // Model: position within an operation. 0 idle, 1 clear, 2 high load, 3 low load,
   // 4 first key step, 5 second key step, 6..POS_DONE-1 run, POS_DONE completion.
   int m_pos;
   bit m_abort;
   bit m_mode;
   int m_count;

   function automatic vec_t mk(bit s, bit md, bit ab, bit iv, logic [2:0] c,
                               bit r, bit cl, bit b, bit d, int n);
      vec_t v;
      v.start = s; v.mode = md; v.abort = ab; v.in_valid = iv;
      v.code = c; v.rdy = r; v.clr = cl; v.bsy = b; v.dn = d; v.cnt = n;
      return v;
   endfunction

   function automatic void modelReset();
      m_pos   = 0;
      m_abort = 0;
      m_mode  = 0;
      m_count = 0;
   endfunction

   function automatic void modelStep(bit s, bit md, bit ab, bit iv);
      if (m_pos == 0) begin
         if (s && !ab) begin
            m_pos   = 1;
            m_abort = 0;
            m_mode  = md;
         end
      end else if (m_pos == 1) begin
         m_pos = m_abort ? 0 : 2;
      end else begin
         if (m_pos == POS_DONE) m_count = (m_count + 1) % 256;
         if (ab) begin
            m_pos   = 1;
            m_abort = 1;
         end else if (m_pos == POS_DONE) begin
            m_pos = 0;
         end else if (!((m_pos == 2 || m_pos == 3) && !iv)) begin
            m_pos = m_pos + 1;
         end
      end
   endfunction

   task automatic checkValue(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input bit iv);
      int exp_code;
      exp_code = 0;
      if (m_pos == 2 && iv) exp_code = 3'b100;
      else if (m_pos == 3 && iv) exp_code = 3'b010;
      else if (m_pos == 4) exp_code = 3'b110;
      else if (m_pos == 5) exp_code = 3'b011;
      else if (m_pos >= 6 && m_pos < POS_DONE) exp_code = m_mode ? 3'b101 : 3'b001;
      checkValue("model.code", int'({bus.out1, bus.out2, bus.out3}), exp_code);
      checkValue("model.in_ready", int'(bus.in_ready), int'(m_pos == 2 || m_pos == 3));
      checkValue("model.dp_clr", int'(bus.dp_clr), int'(m_pos == 1));
      checkValue("model.busy", int'(bus.busy), int'(m_pos != 0));
      checkValue("model.done", int'(bus.done), int'(m_pos == POS_DONE));
      checkValue("model.op_count", int'(bus.op_count), m_count);
   endtask

   // One cycle: drive at posedge+1, sample at negedge, advance the model at posedge.
   task automatic applyStimulus(input bit s, input bit md, input bit ab, input bit iv,
                                input int row);
      bus.start    = s;
      bus.mode     = md;
      bus.abort    = ab;
      bus.in_valid = iv;
      @(negedge clka);
      checkOutput(iv);
      if (row >= 0) begin
         checkValue($sformatf("tbl[%0d].code", row), int'({bus.out1, bus.out2, bus.out3}),
                    int'(vecs[row].code));
         checkValue($sformatf("tbl[%0d].in_ready", row), int'(bus.in_ready), int'(vecs[row].rdy));
         checkValue($sformatf("tbl[%0d].dp_clr", row), int'(bus.dp_clr), int'(vecs[row].clr));
         checkValue($sformatf("tbl[%0d].busy", row), int'(bus.busy), int'(vecs[row].bsy));
         checkValue($sformatf("tbl[%0d].done", row), int'(bus.done), int'(vecs[row].dn));
         checkValue($sformatf("tbl[%0d].op_count", row), int'(bus.op_count), vecs[row].cnt);
      end
      last_done = bus.done;
      @(posedge clka);
      modelStep(s, md, ab, iv);
      #1;
   endtask

   task automatic pulseReset();
      restart = 1'b0;
      @(posedge clka);
      #1;
      restart = 1'b1;
      modelReset();
   endtask

   // Runaway guard.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      int lat;
      bit got;
      int pulses;

      restart      = 1'b0;
      bus.start    = 1'b0;
      bus.mode     = 1'b0;
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      modelReset();

      // Encrypt, in_valid high throughout.
      vecs.push_back(mk(1,0,0,1, 3'b000, 0,0,0,0, 0));
      vecs.push_back(mk(0,0,0,1, 3'b000, 0,1,1,0, 0));
      vecs.push_back(mk(0,0,0,1, 3'b100, 1,0,1,0, 0));
      vecs.push_back(mk(0,0,0,1, 3'b010, 1,0,1,0, 0));
      vecs.push_back(mk(0,0,0,1, 3'b110, 0,0,1,0, 0));
      vecs.push_back(mk(0,0,0,1, 3'b011, 0,0,1,0, 0));
      vecs.push_back(mk(0,0,0,1, 3'b001, 0,0,1,0, 0));
      vecs.push_back(mk(0,0,0,1, 3'b001, 0,0,1,0, 0));
      vecs.push_back(mk(0,0,0,1, 3'b000, 0,0,1,1, 0));
      vecs.push_back(mk(0,0,0,0, 3'b000, 0,0,0,0, 1));
      // Decrypt aborted during the second key step.
      vecs.push_back(mk(1,1,0,1, 3'b000, 0,0,0,0, 1));
      vecs.push_back(mk(0,0,0,1, 3'b000, 0,1,1,0, 1));
      vecs.push_back(mk(0,0,0,1, 3'b100, 1,0,1,0, 1));
      vecs.push_back(mk(0,0,0,1, 3'b010, 1,0,1,0, 1));
      vecs.push_back(mk(0,0,0,1, 3'b110, 0,0,1,0, 1));
      vecs.push_back(mk(0,0,1,1, 3'b011, 0,0,1,0, 1));
      vecs.push_back(mk(0,0,0,1, 3'b000, 0,1,1,0, 1));
      vecs.push_back(mk(0,0,0,1, 3'b000, 0,0,0,0, 1));
      // start+abort in IDLE is ignored; start while busy does not relatch mode.
      vecs.push_back(mk(1,1,1,1, 3'b000, 0,0,0,0, 1));
      vecs.push_back(mk(0,0,0,1, 3'b000, 0,0,0,0, 1));
      vecs.push_back(mk(1,1,0,1, 3'b000, 0,0,0,0, 1));
      vecs.push_back(mk(1,0,0,1, 3'b000, 0,1,1,0, 1));
      vecs.push_back(mk(1,0,0,1, 3'b100, 1,0,1,0, 1));
      vecs.push_back(mk(1,0,0,1, 3'b010, 1,0,1,0, 1));
      vecs.push_back(mk(1,0,0,1, 3'b110, 0,0,1,0, 1));
      vecs.push_back(mk(1,0,0,1, 3'b011, 0,0,1,0, 1));
      vecs.push_back(mk(1,0,0,1, 3'b101, 0,0,1,0, 1));
      vecs.push_back(mk(1,0,0,1, 3'b101, 0,0,1,0, 1));
      vecs.push_back(mk(1,0,0,1, 3'b000, 0,0,1,1, 1));
      vecs.push_back(mk(0,0,0,0, 3'b000, 0,0,0,0, 2));

      // Reset state while restart is held low.
      repeat (2) @(posedge clka);
      #1;
      checkValue("reset.code", int'({bus.out1, bus.out2, bus.out3}), 0);
      checkValue("reset.in_ready", int'(bus.in_ready), 0);
      checkValue("reset.busy", int'(bus.busy), 0);
      checkValue("reset.done", int'(bus.done), 0);
      checkValue("reset.op_count", int'(bus.op_count), 0);
      checkValue("reset.dp_clr", int'(bus.dp_clr), 1);
      restart = 1'b1;
      @(posedge clka);
      #1;

      $display("[TB] directed vector table");
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].start, vecs[i].mode, vecs[i].abort, vecs[i].in_valid, i);
      end

      $display("[TB] decrypt with in_valid low for three high-load cycles");
      applyStimulus(1, 1, 0, 1, -1);
      lat = 0;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         applyStimulus(0, 0, 0, (i >= 1 && i <= 3) ? 1'b0 : 1'b1, -1);
         lat++;
         if (last_done) got = 1;
      end
      checkValue("decrypt.latency", got ? lat : -1, 11);

      $display("[TB] 256 back-to-back operations");
      pulseReset();
      pulses = 0;
      for (int op = 0; op < 256; op++) begin
         applyStimulus(1, 1'(op & 1), 0, 1, -1);
         got = 0;
         for (int k = 0; k < 20 && !got; k++) begin
            applyStimulus(0, 0, 0, 1, -1);
            if (last_done) got = 1;
         end
         if (got) pulses++;
         if (op == 254) checkValue("wrap.op_count_255", int'(bus.op_count), 255);
      end
      checkValue("wrap.done_pulses", pulses, 256);
      checkValue("wrap.op_count_0", int'(bus.op_count), 0);

      $display("[TB] asynchronous restart during RUN");
      applyStimulus(1, 0, 0, 1, -1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, -1);
      bus.start = 1'b0;
      #2;
      checkValue("async.busy_before", int'(bus.busy), 1);
      restart = 1'b0;
      #1;
      checkValue("async.busy", int'(bus.busy), 0);
      checkValue("async.code", int'({bus.out1, bus.out2, bus.out3}), 0);
      checkValue("async.dp_clr", int'(bus.dp_clr), 1);
      checkValue("async.done", int'(bus.done), 0);
      checkValue("async.op_count", int'(bus.op_count), 0);
      @(posedge clka);
      #1;
      checkValue("async.dp_clr_held", int'(bus.dp_clr), 1);
      restart = 1'b1;
      modelReset();
      applyStimulus(0, 0, 0, 0, -1);
      checkValue("async.idle_after", int'(bus.busy), 0);

      $display("[TB] randomized run against model");
      for (int i = 0; i < 2000; i++) begin
         applyStimulus($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
